// File: rtl/rew_mask_xor.sv
`default_nettype none
// ============================================================================
// Module   : rew_mask_xor
// Purpose  : Packs AES mask chunks into flit-wide masks and XORs them onto
//            DRAM flits; bypass flits pass through untouched.
//            Optional macro REW_MASK_XOR_STALLCNT_EN adds StallCount.
// Revision : 1.0 - initial release
// ============================================================================
module rew_mask_xor #(
  parameter int DDRDWidth = 512,
  parameter int AESWidth  = 128,
  parameter int MaskDepth = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [AESWidth-1:0]          MaskIn,
  input  logic                         MaskInValid,
  output logic                         MaskInReady,
  input  logic [DDRDWidth-1:0]         DataIn,
  input  logic                         DataInBypass,
  input  logic                         DataInValid,
  output logic                         DataInReady,
  output logic [DDRDWidth-1:0]         DataOut,
  output logic                         DataOutValid,
  input  logic                         DataOutReady,
  output logic [$clog2(MaskDepth):0]   MaskCount
`ifdef REW_MASK_XOR_STALLCNT_EN
  ,
  output logic [31:0]                  StallCount
`endif
);

  localparam int CHUNKS = DDRDWidth / AESWidth;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PTR_W  = $clog2(MaskDepth);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(MaskDepth);

  logic [CNT_W-1:0]     chunk_cnt_q, chunk_cnt_d;
  logic [DDRDWidth-1:0] pack_q,      pack_d;
  logic [DDRDWidth-1:0] mem_q [MaskDepth];
  logic [DDRDWidth-1:0] mem_d [MaskDepth];
  logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
  logic [LVL_W-1:0]     level_q,     level_d;
  logic                 out_valid_q, out_valid_d;
  logic [DDRDWidth-1:0] out_data_q,  out_data_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 mask_acc;
  logic                 fifo_wr;
  logic                 fifo_pop;
  logic                 out_free;
  logic                 data_acc;
  logic [DDRDWidth-1:0] fifo_head;

  assign fifo_full   = (level_q == FULL_LEVEL);
  assign fifo_empty  = (level_q == '0);
  assign out_free    = ~out_valid_q | DataOutReady;
  assign MaskInReady = ~fifo_full;
  assign DataInReady = out_free & (DataInBypass | ~fifo_empty);
  assign mask_acc    = MaskInValid & MaskInReady;
  assign data_acc    = DataInValid & DataInReady;
  assign fifo_wr     = mask_acc & (chunk_cnt_q == LAST_CHUNK);
  assign fifo_pop    = data_acc & ~DataInBypass;
  // Head comes from the registered array, so a same-cycle write is never seen
  assign fifo_head   = mem_q[rd_ptr_q];

  assign DataOut      = out_data_q;
  assign DataOutValid = out_valid_q;
  assign MaskCount    = level_q;

  // Mask packing: the incoming chunk lands in the slot selected by the counter
  always_comb begin
    pack_d      = pack_q;
    chunk_cnt_d = chunk_cnt_q;
    for (int k = 0; k < CHUNKS; k++) begin
      if (chunk_cnt_q == CNT_W'(k)) begin
        pack_d[k*AESWidth +: AESWidth] = MaskIn;
      end
    end
    if (!mask_acc) begin
      pack_d = pack_q;
    end else if (chunk_cnt_q == LAST_CHUNK) begin
      chunk_cnt_d = '0;
    end else begin
      chunk_cnt_d = chunk_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = pack_d;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({fifo_wr, fifo_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (data_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = DataInBypass ? DataIn : (DataIn ^ fifo_head);
    end else if (DataOutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      chunk_cnt_q <= '0;
      pack_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      chunk_cnt_q <= chunk_cnt_d;
      pack_q      <= pack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage array needs no reset: the pointers and level define validity
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

`ifdef REW_MASK_XOR_STALLCNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (DataInValid && !DataInBypass && fifo_empty && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign StallCount = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rew_mask_xor.sv
`default_nettype none
// Directed self-checking bench for rew_mask_xor (default parameters).
module tb_rew_mask_xor;

  localparam int DW = 512;
  localparam int AW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mask_in;
  logic          mask_in_valid;
  logic          mask_in_ready;
  logic [DW-1:0] data_in;
  logic          data_in_bypass;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [2:0]    mask_count;
`ifdef REW_MASK_XOR_STALLCNT_EN
  logic [31:0]   stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stream_exp [16];
  int            sink_k;

  always #5 clk = ~clk;

  rew_mask_xor dut (
    .Clock        (clk),
    .Reset        (rst),
    .MaskIn       (mask_in),
    .MaskInValid  (mask_in_valid),
    .MaskInReady  (mask_in_ready),
    .DataIn       (data_in),
    .DataInBypass (data_in_bypass),
    .DataInValid  (data_in_valid),
    .DataInReady  (data_in_ready),
    .DataOut      (data_out),
    .DataOutValid (data_out_valid),
    .DataOutReady (data_out_ready),
    .MaskCount    (mask_count)
`ifdef REW_MASK_XOR_STALLCNT_EN
    ,
    .StallCount   (stall_count)
`endif
  );

  function automatic logic [DW-1:0] mk(input int c0, input int c1, input int c2, input int c3);
    return {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mask_in        = '0;
    mask_in_valid  = 1'b0;
    data_in        = '0;
    data_in_bypass = 1'b0;
    data_in_valid  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    data_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_chunk(input int v);
    int n;
    n = 0;
    mask_in       = AW'(v);
    mask_in_valid = 1'b1;
    #1;
    while (!mask_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL push_timeout: MaskInReady got 0 expected 1 within 50 cycles");
    end
    tick();
    mask_in_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [DW-1:0] d, input logic byp);
    int n;
    n = 0;
    data_in        = d;
    data_in_bypass = byp;
    data_in_valid  = 1'b1;
    #1;
    while (!data_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL flit_timeout: DataInReady got 0 expected 1 within 50 cycles");
    end
    tick();
    data_in_valid  = 1'b0;
    data_in_bypass = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    data_out_ready = 1'b0;
    tick();
    tick();
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", data_out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", data_out); end
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", mask_count); end
    checks++; if (mask_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mready: got %b expected 1", mask_in_ready); end
    checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL rst_dready: got %b expected 0", data_in_ready); end
    data_in_bypass = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_dready_byp: got %b expected 1", data_in_ready); end
    data_in_bypass = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic;
    data_out_ready = 1'b1;
    push_chunk(1);
    push_chunk(2);
    push_chunk(3);
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL basic_partial_count: got %0d expected 0", mask_count); end
    push_chunk(4);
    checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", mask_count); end
    data_in = '0; data_in_bypass = 1'b0; data_in_valid = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL basic_dready: got %b expected 1", data_in_ready); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid: got %b expected 0", data_out_valid); end
    tick();
    data_in_valid = 1'b0;
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL basic_data: got %h expected %h", data_out, mk(1, 2, 3, 4)); end
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", mask_count); end
    tick();
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", data_out_valid); end
  endtask

  task automatic test_bypass_stall;
    logic [DW-1:0] x;
    x = {16{32'h0F0F_1234}};
    do_reset();
    data_in = DW'(16'hDEAD); data_in_bypass = 1'b1; data_in_valid = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL byp_dready: got %b expected 1", data_in_ready); end
    tick();
    checks++; if (data_out !== DW'(16'hDEAD) || data_out_valid !== 1'b1) begin errors++; $display("FAIL byp_data: got %h expected dead", data_out); end
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL byp_nopop: got %0d expected 0", mask_count); end
    data_in = x; data_in_bypass = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mask_in = AW'(5 + c); mask_in_valid = 1'b1;
      #1;
      checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL stall_dready%0d: got %b expected 0", c, data_in_ready); end
      tick();
    end
    mask_in_valid = 1'b0;
    #1;
    checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", mask_count); end
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", data_in_ready); end
`ifdef REW_MASK_XOR_STALLCNT_EN
    checks++; if (stall_count !== 32'd4) begin errors++; $display("FAIL stallcnt: got %0d expected 4", stall_count); end
`endif
    tick();
    data_in_valid = 1'b0;
    checks++; if (data_out !== (x ^ mk(5, 6, 7, 8))) begin errors++; $display("FAIL stall_data: got %h expected %h", data_out, x ^ mk(5, 6, 7, 8)); end
  endtask

  task automatic test_full;
    logic [DW-1:0] exp_m [4];
    exp_m[0] = mk(5, 6, 7, 8);
    exp_m[1] = mk(9, 10, 11, 12);
    exp_m[2] = mk(13, 14, 15, 16);
    exp_m[3] = mk(17, 18, 19, 20);
    do_reset();
    data_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_chunk(i + 1);
    checks++; if (mask_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", mask_count); end
    checks++; if (mask_in_ready !== 1'b0) begin errors++; $display("FAIL full_mready: got %b expected 0", mask_in_ready); end
    mask_in = AW'(17); mask_in_valid = 1'b1;
    tick();
    tick();
    checks++; if (mask_count !== 3'd4 || mask_in_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got count %0d ready %b expected 4 0", mask_count, mask_in_ready); end
    data_in = '0; data_in_bypass = 1'b0; data_in_valid = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL full_dready: got %b expected 1", data_in_ready); end
    tick();
    data_in_valid = 1'b0;
    checks++; if (data_out !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL full_first: got %h expected %h", data_out, mk(1, 2, 3, 4)); end
    checks++; if (mask_count !== 3'd3) begin errors++; $display("FAIL full_pop: got %0d expected 3", mask_count); end
    tick();
    mask_in_valid = 1'b0;
    checks++; if (data_out !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL full_stable: got %h expected %h", data_out, mk(1, 2, 3, 4)); end
    push_chunk(18);
    push_chunk(19);
    push_chunk(20);
    checks++; if (mask_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", mask_count); end
    data_out_ready = 1'b1;
    data_in = '0; data_in_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      tick();
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== exp_m[f]) begin
        errors++; $display("FAIL full_order%0d: got %h expected %h", f, data_out, exp_m[f]);
      end
    end
    data_in_valid = 1'b0;
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", mask_count); end
  endtask

  task automatic test_alt_stream;
    int mi;
    int fi;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stream_exp[i] = {16{32'hC0DE_0000 + 32'(i)}};
      if (i % 2 == 1) stream_exp[i] = stream_exp[i] ^ mk(101 + 2*(i-1), 102 + 2*(i-1), 103 + 2*(i-1), 104 + 2*(i-1));
    end
    sink_k = 0;
    mi = 0;
    fi = 0;
    fork
      begin
        int n;
        logic acc;
        n = 0;
        while (mi < 32 && n < 800) begin
          mask_in = AW'(101 + mi); mask_in_valid = 1'b1;
          @(negedge clk); acc = mask_in_ready;
          @(posedge clk); #1;
          if (acc) mi++;
          n++;
        end
        mask_in_valid = 1'b0;
      end
      begin
        int n;
        logic acc;
        n = 0;
        while (fi < 16 && n < 800) begin
          data_in = {16{32'hC0DE_0000 + 32'(fi)}};
          data_in_bypass = (fi % 2 == 0);
          data_in_valid = 1'b1;
          @(negedge clk); acc = data_in_ready;
          @(posedge clk); #1;
          if (acc) fi++;
          n++;
        end
        data_in_valid = 1'b0;
        data_in_bypass = 1'b0;
      end
      begin
        int cyc;
        logic hold;
        logic [DW-1:0] held;
        cyc = 0; hold = 1'b0; held = '0;
        while (sink_k < 16 && cyc < 800) begin
          data_out_ready = ((cyc / 2) % 2) == 0;
          @(negedge clk);
          if (hold) begin
            checks++;
            if (data_out !== held) begin errors++; $display("FAIL alt_stable: got %h expected %h", data_out, held); end
          end
          if (data_out_valid && data_out_ready) begin
            checks++;
            if (data_out !== stream_exp[sink_k]) begin errors++; $display("FAIL alt_out%0d: got %h expected %h", sink_k, data_out, stream_exp[sink_k]); end
            sink_k++;
            hold = 1'b0;
          end else if (data_out_valid) begin
            hold = 1'b1;
            held = data_out;
          end else begin
            hold = 1'b0;
          end
          @(posedge clk); #1;
          cyc++;
        end
        data_out_ready = 1'b1;
      end
    join
    checks++; if (sink_k != 16) begin errors++; $display("FAIL alt_outputs: got %0d expected 16", sink_k); end
    checks++; if (mi != 32 || fi != 16) begin errors++; $display("FAIL alt_inputs: got %0d chunks %0d flits expected 32 16", mi, fi); end
    checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL alt_consumed: got %0d expected 0", mask_count); end
  endtask

  task automatic test_reset_midpack;
    do_reset();
    data_out_ready = 1'b0;
    push_chunk(32'hAA);
    push_chunk(32'hBB);
    send_flit(DW'(16'hBEEF), 1'b1);
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", data_out_valid); end
    rst = 1'b1;
    tick();
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || mask_count !== 3'd0 || mask_in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst: got valid %b data %h count %0d mready %b expected 0 0 0 1", data_out_valid, data_out, mask_count, mask_in_ready);
    end
    rst = 1'b0;
    data_out_ready = 1'b1;
    push_chunk(32'h11);
    push_chunk(32'h22);
    push_chunk(32'h33);
    push_chunk(32'h44);
    checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL mid_count: got %0d expected 1", mask_count); end
    send_flit('0, 1'b0);
    checks++; if (data_out !== mk(32'h11, 32'h22, 32'h33, 32'h44)) begin errors++; $display("FAIL mid_data: got %h expected %h", data_out, mk(32'h11, 32'h22, 32'h33, 32'h44)); end
  endtask

  task automatic test_simul_wr_pop;
    do_reset();
    data_out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) push_chunk(i);
    checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL sim_pre: got %0d expected 1", mask_count); end
    mask_in = AW'(8); mask_in_valid = 1'b1;
    data_in = '0; data_in_bypass = 1'b0; data_in_valid = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1 || mask_in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got d %b m %b expected 1 1", data_in_ready, mask_in_ready); end
    tick();
    mask_in_valid = 1'b0;
    data_in_valid = 1'b0;
    checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL sim_count: got %0d expected 1", mask_count); end
    checks++; if (data_out !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL sim_old: got %h expected %h", data_out, mk(1, 2, 3, 4)); end
    send_flit('0, 1'b0);
    checks++; if (data_out !== mk(5, 6, 7, 8) || mask_count !== 3'd0) begin errors++; $display("FAIL sim_new: got %h count %0d expected %h 0", data_out, mask_count, mk(5, 6, 7, 8)); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    data_out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_bypass_stall();
    test_full();
    test_alt_stream();
    test_reset_midpack();
    test_simul_wr_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rew_mask_xor.md
REW_MASK_XOR -- requirements
Module: rew_mask_xor

Interface
REQ-001 SHALL have parameter DDRDWidth, default 512, DRAM flit width in bits.
REQ-002 SHALL have parameter AESWidth, default 128, AES mask chunk width; DDRDWidth SHALL be an integer multiple of AESWidth; Chunks = DDRDWidth/AESWidth (4 by default).
REQ-003 SHALL have parameter MaskDepth, default 4, packed-mask FIFO depth in flits; must be a power of 2, minimum 2.
REQ-004 SHALL have ports, in this order:
- Clock  in  1  single clock.
- Reset  in  1  synchronous, active-high.
- MaskIn  in  AESWidth  AES output mask chunk.
- MaskInValid  in  1
- MaskInReady  out  1
- DataIn  in  DDRDWidth  path flit.
- DataInBypass  in  1  flit passes unmodified; no mask consumed.
- DataInValid  in  1
- DataInReady  out  1
- DataOut  out  DDRDWidth  XORed or bypassed flit.
- DataOutValid  out  1
- DataOutReady  in  1
- MaskCount  out  log2(MaskDepth)+1  number of packed masks buffered.

Function
REQ-005 SHALL transfer on any port only when Valid and Ready are both high on a rising Clock edge; DataInBypass is qualified by DataInValid.
REQ-006 SHALL pack Chunks consecutive accepted MaskIn chunks into one DDRDWidth mask, with chunk k at bits [(k+1)*AESWidth-1 : k*AESWidth] (first chunk at the LSBs).
REQ-007 SHALL keep a chunk counter 0..Chunks-1; it SHALL wrap to 0 on acceptance of chunk Chunks-1, and that cycle SHALL write the packed word into the mask FIFO.
REQ-008 SHALL drive MaskInReady = mask FIFO not full; a partially packed word SHALL never be lost or overwritten.
REQ-009 SHALL have a one-entry output register; it is free when empty or when DataOutReady is high this cycle.
REQ-010 SHALL drive DataInReady = (output register free) AND (DataInBypass OR mask FIFO non-empty).
REQ-011 On a non-bypass accept, SHALL load DataIn XOR the FIFO head into the output register and pop the FIFO in the same cycle.
REQ-012 On a bypass accept, SHALL load DataIn unchanged and SHALL NOT pop the FIFO.
REQ-013 Latency SHALL be 1 cycle: DataOutValid rises the edge after the accept; sustained throughput SHALL be 1 flit per cycle when masks are available and DataOutReady is high.
REQ-014 A FIFO write (REQ-007) and pop (REQ-011) in the same cycle SHALL leave MaskCount unchanged and SHALL be legal at both full and empty; at empty, the pop SHALL use only a word already resident, never the one being written.
REQ-015 MaskCount SHALL equal the number of full packed masks held and SHALL update on the edge after a write or pop.
REQ-016 DataOut SHALL hold stable while DataOutValid is high and DataOutReady is low.
REQ-017 Flit order and mask order SHALL be preserved: the n-th non-bypass flit SHALL be XORed with the n-th packed mask.

Reset
REQ-018 On Reset, SHALL clear: chunk counter to 0, mask FIFO to empty, MaskCount to 0, DataOutValid to 0, DataOut to 0, MaskInReady to 1 on the first cycle after Reset, DataInReady to 0 unless DataInBypass.
REQ-019 A Reset asserted mid-packing or mid-transfer SHALL discard all partial and buffered masks and flits with no output.

Configuration
REQ-020 Macro REW_MASK_XOR_STALLCNT_EN:
- Defined: SHALL add output StallCount (32 bits, last port), reset to 0, incremented each cycle DataInValid AND NOT DataInBypass AND mask FIFO empty, saturating at 32'hFFFFFFFF.
- Undefined: the port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-021 Masks 0x1,0x2,0x3,0x4 (128-bit each), then one non-bypass flit of all-zero -> DataOut = {0x4,0x3,0x2,0x1} concatenated MSB to LSB, one cycle after the accept; MaskCount goes 0->1->0.
REQ-022 MaskCount=0, bypass flit 0xDEAD -> DataOut=0xDEAD next cycle; a non-bypass flit then stalls (DataInReady=0) until 4 chunks arrive; with the macro defined, StallCount = stall cycles.
REQ-023 Fill 4 packed masks with DataOutReady=0 -> MaskInReady=0 and MaskCount=4; a 17th chunk is held; release -> no chunk lost, order preserved.
REQ-024 Continuous stream of 16 flits alternating bypass/non-bypass with DataOutReady toggling every 2 cycles -> 16 outputs in order, 8 masks consumed, DataOut stable while stalled.
REQ-025 Reset after 2 of 4 chunks accepted, then 4 new chunks -> the first output mask uses only the post-reset chunks; all outputs at reset values the cycle after Reset.
REQ-026 FIFO at MaskCount=1, 4th chunk accepted and non-bypass flit accepted in the same cycle -> MaskCount stays 1; the flit is XORed with the older mask.
